ad_ip_jesd204_tpl_dac_fifo: RTL and testbench

Elastic sample buffer between the DMA stream and the TPL DAC core, in the `link_clk` domain. Accepts beats of `NUM_LANES*32` bits over a valid/ready stream and holds them until a prefill threshold is met. Returns one beat per TPL read strobe (`|dac_valid`). When empty while running it substitutes zeros and raises `dac_dunf`, which the TPL regmap consumes.

---
 rtl/ad_ip_jesd204_tpl_dac_fifo_pkg.sv | 18 +
 rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv | 29 ++
 rtl/ad_ip_jesd204_tpl_dac_fifo.sv | 105 ++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_fifo_pkg.sv
// Shared definitions for the JESD204 TPL sample FIFOs (DAC side and ADC side).
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ad_ip_jesd204_tpl_dac_fifo_pkg;

    // FIFO control state; the encoding is shared with the ADC-side buffer.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } tpl_fifo_state_t;

    // Beat width in bits for a given number of link lanes (32 bits per lane).
    function automatic int tpl_dw(input int num_lanes);
        return num_lanes * 32;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv
// Simple dual-port sample RAM: one write port, one synchronously read port.
// Latency: 1 cycle from rd_en to rd_data; rd_data holds when rd_en is low.
// Backpressure: none; the parent never writes a full buffer or reads an empty one.
module ad_ip_jesd204_tpl_dac_fifo_mem #(
    parameter int DW = 128,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] ram [2**AW];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_addr] <= wr_data;
    end

    // Registered read port; this register is the parent's output stage.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_fifo.sv
// Elastic DMA-to-TPL DAC sample buffer with prefill threshold and underflow zero-fill.
// Latency: 1 cycle from a read strobe to dac_ddata / dac_dunf.
// Backpressure: s_axis_ready low while idle or full; reads are never stalled (zeros on empty).
module ad_ip_jesd204_tpl_dac_fifo
    import ad_ip_jesd204_tpl_dac_fifo_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int NUM_CHANNELS = 2,
    parameter int DEPTH_LOG2   = 4,
    parameter int START_LEVEL  = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_CHANNELS-1:0]       enable,
    input  logic                          s_axis_valid,
    output logic                          s_axis_ready,
    input  logic [tpl_dw(NUM_LANES)-1:0]  s_axis_data,
    input  logic [NUM_CHANNELS-1:0]       dac_valid,
    output logic [tpl_dw(NUM_LANES)-1:0]  dac_ddata,
    output logic                          dac_dunf,
    output logic [DEPTH_LOG2:0]           level
);

    localparam int DW = tpl_dw(NUM_LANES);
    localparam logic [DEPTH_LOG2:0]   FULL      = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0]   START_LVL = (DEPTH_LOG2+1)'(START_LEVEL);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    tpl_fifo_state_t       state;
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic                  zero_sel;
    logic [DW-1:0]         mem_data;

    logic rd;
    logic en;
    logic push;
    logic pop;
    logic underflow;

    assign rd           = |dac_valid;
    assign en           = |enable;
    // Ready uses the registered level, so a same-cycle pop never opens room at full.
    assign s_axis_ready = (state != ST_IDLE) && (level != FULL);
    assign push         = s_axis_valid && s_axis_ready;
    // No bypass: an empty buffer underflows even if a beat arrives this cycle.
    assign pop          = rd && (state == ST_RUN) && (level != '0);
    assign underflow    = rd && (state == ST_RUN) && (level == '0);

    // FSM, pointers and occupancy; dropping enable flushes everything in one edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else if (!en) begin
            state <= ST_IDLE;
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            case (state)
                ST_IDLE:    state <= ST_PREFILL;
                ST_PREFILL: if (level >= START_LVL) state <= ST_RUN;
                default:    state <= ST_RUN;
            endcase
            if (push) wp <= wp + PTR_ONE;
            if (pop)  rp <= rp + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Output qualifiers: zero-select follows each read, underflow is a one-cycle pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            zero_sel <= 1'b1;
            dac_dunf <= 1'b0;
        end else begin
            if (rd) zero_sel <= !pop;
            dac_dunf <= underflow;
        end
    end

    ad_ip_jesd204_tpl_dac_fifo_mem #(
        .DW (DW),
        .AW (DEPTH_LOG2)
    ) i_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wp),
        .wr_data (s_axis_data),
        .rd_en   (pop),
        .rd_addr (rp),
        .rd_data (mem_data)
    );

    assign dac_ddata = zero_sel ? '0 : mem_data;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_fifo.sv
// Self-checking bench for the TPL DAC sample FIFO: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue-based model.
// Clock period 10; inputs change 1 time unit after the rising edge, outputs compared on the falling edge.
module tb_ad_ip_jesd204_tpl_dac_fifo;

    localparam int DW    = 128;
    localparam int DEPTH = 16;
    localparam int START = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [1:0]    enable = 2'b00;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic [DW-1:0] s_axis_data = '0;
    logic [1:0]    dac_valid = 2'b00;
    logic [DW-1:0] dac_ddata;
    logic          dac_dunf;
    logic [4:0]    level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_dac_fifo #(
        .NUM_LANES    (4),
        .NUM_CHANNELS (2),
        .DEPTH_LOG2   (4),
        .START_LEVEL  (START)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_data  (s_axis_data),
        .dac_valid    (dac_valid),
        .dac_ddata    (dac_ddata),
        .dac_dunf     (dac_dunf),
        .level        (level)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = disabled, 1 = filling, 2 = streaming
    int            m_mode = 0;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_ddata = '0;
    logic          m_dunf = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_mode  = 0;
            m_q.delete();
            m_ddata = '0;
            m_dunf  = 1'b0;
        end else begin
            int  lvl;
            bit  rd_now;
            bit  accept;
            lvl    = m_q.size();
            rd_now = (dac_valid != 2'b00);
            accept = s_axis_valid && (m_mode != 0) && (lvl != DEPTH);
            m_dunf = rd_now && (m_mode == 2) && (lvl == 0);
            if (rd_now) begin
                if (m_mode == 2 && lvl != 0) m_ddata = m_q.pop_front();
                else                         m_ddata = '0;
            end
            if (accept) m_q.push_back(s_axis_data);
            if (enable == 2'b00) begin
                m_mode = 0;
                m_q.delete();
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1 && lvl >= START) begin
                m_mode = 2;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (resetn) begin
            chk("level", DW'(level), DW'(m_q.size()));
            chk("s_axis_ready", DW'(s_axis_ready),
                DW'((m_mode != 0) && (m_q.size() != DEPTH)));
            chk("dac_ddata", dac_ddata, m_ddata);
            chk("dac_dunf", DW'(dac_dunf), DW'(m_dunf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_axis_valid = 1'b1;
            s_axis_data  = DW'(base + i);
            step();
        end
        s_axis_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", DW'(level), DW'(0));
        chk("rst_ready", DW'(s_axis_ready), DW'(0));
        chk("rst_ddata", dac_ddata, DW'(0));
        chk("rst_dunf", DW'(dac_dunf), DW'(0));
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Prefill with beats 1..8, then one cycle to enter streaming
        enable = 2'b11;
        step();
        chk("pf_ready", DW'(s_axis_ready), DW'(1));
        push_n(8, 1);
        chk("pf_level8", DW'(level), DW'(8));
        step();
        chk("run_ready", DW'(s_axis_ready), DW'(1));

        // Drain 8 beats then underflow twice
        dac_valid = 2'b11;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k <= 8) begin
                chk("drain_data", dac_ddata, DW'(k));
                chk("drain_dunf", DW'(dac_dunf), DW'(0));
            end else begin
                chk("unf_data", dac_ddata, DW'(0));
                chk("unf_dunf", DW'(dac_dunf), DW'(1));
            end
        end
        dac_valid = 2'b00;
        step();
        chk("dunf_not_sticky", DW'(dac_dunf), DW'(0));

        // Fill to full, then push and read together
        push_n(16, 100);
        chk("full_level", DW'(level), DW'(16));
        chk("full_ready", DW'(s_axis_ready), DW'(0));
        s_axis_valid = 1'b1;
        s_axis_data  = DW'(999);
        dac_valid    = 2'b01;
        step();
        s_axis_valid = 1'b0;
        dac_valid    = 2'b00;
        chk("full_pop_level", DW'(level), DW'(15));
        chk("full_pop_data", dac_ddata, DW'(100));

        // Flush, re-enable, read during prefill
        enable = 2'b00;
        step();
        chk("flush_level", DW'(level), DW'(0));
        chk("flush_ready", DW'(s_axis_ready), DW'(0));
        enable = 2'b10;
        step();
        push_n(3, 200);
        dac_valid = 2'b10;
        step();
        dac_valid = 2'b00;
        chk("pf_rd_data", dac_ddata, DW'(0));
        chk("pf_rd_dunf", DW'(dac_dunf), DW'(0));
        chk("pf_rd_level", DW'(level), DW'(3));

        // Reach streaming, pop down to 5, drop enable mid-run
        push_n(5, 203);
        step();
        dac_valid = 2'b11;
        repeat (3) step();
        dac_valid = 2'b00;
        chk("mid_level5", DW'(level), DW'(5));
        chk("mid_data", dac_ddata, DW'(202));
        enable = 2'b00;
        step();
        chk("mid_off_level", DW'(level), DW'(0));
        chk("mid_off_ready", DW'(s_axis_ready), DW'(0));
        enable = 2'b11;
        step();
        chk("reen_ready", DW'(s_axis_ready), DW'(1));
        chk("reen_level", DW'(level), DW'(0));
        dac_valid = 2'b01;
        step();
        dac_valid = 2'b00;
        chk("reen_rd_dunf", DW'(dac_dunf), DW'(0));
        chk("reen_rd_data", dac_ddata, DW'(0));

        // Asynchronous reset at level 10 with nonzero output
        push_n(11, 300);
        step();
        dac_valid = 2'b01;
        step();
        dac_valid = 2'b00;
        chk("pre_rst_level", DW'(level), DW'(10));
        chk("pre_rst_data", dac_ddata, DW'(300));
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_level", DW'(level), DW'(0));
        chk("arst_ddata", dac_ddata, DW'(0));
        chk("arst_dunf", DW'(dac_dunf), DW'(0));
        chk("arst_ready", DW'(s_axis_ready), DW'(0));
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Randomized traffic in phases with different write/read pressure
        for (int p = 0; p < 4; p++) begin
            int wr_pct;
            int rd_pct;
            wr_pct = (p == 0) ? 80 : (p == 1) ? 30 : (p == 2) ? 60 : 95;
            rd_pct = (p == 0) ? 30 : (p == 1) ? 80 : (p == 2) ? 60 : 10;
            for (int c = 0; c < 800; c++) begin
                s_axis_valid = ($urandom_range(99) < wr_pct);
                s_axis_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                dac_valid    = ($urandom_range(99) < rd_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
                if ($urandom_range(199) == 0) enable = 2'b00;
                else if (enable == 2'b00)      enable = 2'($urandom_range(3, 1));
                step();
            end
        end
        s_axis_valid = 1'b0;
        dac_valid    = 2'b00;
        step();
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
